// File: rtl/md_step_sequencer.sv
// md_step_sequencer: timestep sequencer for the MD engine.
//
// Divides fast_clk into slow_clk and a one-cycle tick strobe. Every state and
// output register below the divider advances only on fast_clk edges where tick
// is high, so all outputs hold for a whole slow period.
//
// Ports:
//   fast_clk, reset           sole clock; asynchronous active-high reset
//   data_in_valid/ready       LOAD handshake for particle words
//   data_in[255:0]            [95:0] pos, [191:96] vel, [199:192] cell, [200+:ADDR_W] addr
//   start, n_steps            begin a run of n_steps timesteps (from WAIT_START or DONE)
//   p1_done, p3_done          phase-1 complete; per-cell phase-3 complete
//   slow_clk, tick            divided clock and its rising-edge strobe
//   mem_set                   all N_PARTICLES words have been accepted
//   phase1_ready/phase3_ready BRAM ownership (never both high)
//   double_buffer             active buffer select, toggled every completed step
//   init_wea/addr/pdata/vdata one-hot BRAM load write port
//   step_count, busy, done    run progress
//   err_bad_cell              sticky: a word named a cell index >= N_CELL
module md_step_sequencer #(
  parameter int N_CELL      = 27,
  parameter int N_PARTICLES = 300,
  parameter int ADDR_W      = 9,
  parameter int DIV         = 8,
  parameter int SETTLE      = 99,
  parameter int STEP_W      = 16
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic [255:0]      data_in,
  input  logic              start,
  input  logic [STEP_W-1:0] n_steps,
  input  logic              p1_done,
  input  logic [N_CELL-1:0] p3_done,
  output logic              slow_clk,
  output logic              tick,
  output logic              mem_set,
  output logic              phase1_ready,
  output logic              phase3_ready,
  output logic              double_buffer,
  output logic [N_CELL-1:0] init_wea,
  output logic [ADDR_W-1:0] init_addr,
  output logic [96:0]       init_pdata,
  output logic [96:0]       init_vdata,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              done,
  output logic              err_bad_cell
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(N_PARTICLES + 1);
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_LOAD       = 3'd0,
    S_WAIT_START = 3'd1,
    S_PHASE1     = 3'd2,
    S_SETTLE     = 3'd3,
    S_PHASE3     = 3'd4,
    S_SWAP       = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  logic [DIV_W-1:0]  div_cnt_r;
  state_t            state_r, state_nx_s;
  logic [CNT_W-1:0]  load_cnt_r, load_cnt_nx_s;
  logic [SET_W-1:0]  settle_cnt_r, settle_cnt_nx_s;
  logic [STEP_W-1:0] n_steps_r, n_steps_nx_s, step_count_nx_s;
  logic              dbuf_nx_s, mem_set_nx_s, err_nx_s;
  logic [N_CELL-1:0] wea_nx_s, cell_onehot_s;
  logic [ADDR_W-1:0] addr_nx_s;
  logic [96:0]       pdata_nx_s, vdata_nx_s;
  logic [7:0]        cell_s;
  logic              cell_ok_s, load_last_s;
  logic              unused_data_s;

  assign cell_s        = data_in[199:192];
  assign cell_ok_s     = (cell_s < 8'(N_CELL));
  assign load_last_s   = (load_cnt_r == CNT_W'(N_PARTICLES - 1));
  assign unused_data_s = ^data_in[255:200+ADDR_W];

  // One-hot write enable for the addressed cell; all zero for an out-of-range cell.
  always_comb begin
    cell_onehot_s = '0;
    for (int i = 0; i < N_CELL; i++) begin
      cell_onehot_s[i] = (cell_s == 8'(i));
    end
  end

  // Clock divider: slow_clk toggles every DIV fast cycles; tick marks its rising edge.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= '0;
      slow_clk  <= 1'b0;
      tick      <= 1'b0;
    end else if (div_cnt_r == DIV_W'(DIV - 1)) begin
      div_cnt_r <= '0;
      slow_clk  <= ~slow_clk;
      tick      <= ~slow_clk;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
      tick      <= 1'b0;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nx_s      = state_r;
    load_cnt_nx_s   = load_cnt_r;
    settle_cnt_nx_s = settle_cnt_r;
    n_steps_nx_s    = n_steps_r;
    step_count_nx_s = step_count;
    dbuf_nx_s       = double_buffer;
    mem_set_nx_s    = mem_set;
    err_nx_s        = err_bad_cell;
    wea_nx_s        = '0;
    addr_nx_s       = init_addr;
    pdata_nx_s      = init_pdata;
    vdata_nx_s      = init_vdata;
    case (state_r)
      S_LOAD: begin
        if (data_in_valid) begin
          // A bad cell is still counted toward N_PARTICLES, it just writes nothing.
          wea_nx_s      = cell_onehot_s;
          addr_nx_s     = data_in[200 +: ADDR_W];
          pdata_nx_s    = {1'b0, data_in[95:0]};
          vdata_nx_s    = {1'b0, data_in[191:96]};
          err_nx_s      = err_bad_cell | ~cell_ok_s;
          load_cnt_nx_s = load_cnt_r + CNT_W'(1);
          if (load_last_s) begin
            mem_set_nx_s = 1'b1;
            state_nx_s   = S_WAIT_START;
          end else begin
            state_nx_s   = S_LOAD;
          end
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      S_WAIT_START, S_DONE: begin
        // A restart from DONE keeps double_buffer and the loaded memory.
        if (start) begin
          n_steps_nx_s    = n_steps;
          step_count_nx_s = STEP_W'(0);
          if (n_steps == STEP_W'(0)) begin
            state_nx_s = S_DONE;
          end else begin
            state_nx_s = S_PHASE1;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      S_PHASE1: begin
        if (p1_done) begin
          state_nx_s      = S_SETTLE;
          settle_cnt_nx_s = SET_W'(0);
        end else begin
          state_nx_s = S_PHASE1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_r == SET_W'(SETTLE - 1)) begin
          state_nx_s = S_PHASE3;
        end else begin
          settle_cnt_nx_s = settle_cnt_r + SET_W'(1);
        end
      end
      S_PHASE3: begin
        // Buffer flip and step increment are registered on entry to SWAP.
        if (&p3_done) begin
          state_nx_s      = S_SWAP;
          dbuf_nx_s       = ~double_buffer;
          step_count_nx_s = step_count + STEP_W'(1);
        end else begin
          state_nx_s = S_PHASE3;
        end
      end
      S_SWAP: begin
        if (step_count == n_steps_r) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_PHASE1;
        end
      end
      default: begin
        state_nx_s = S_LOAD;
      end
    endcase
  end

  // State and output registers, advanced once per slow period on tick.
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_LOAD;
      load_cnt_r    <= '0;
      settle_cnt_r  <= '0;
      n_steps_r     <= '0;
      step_count    <= '0;
      double_buffer <= 1'b0;
      mem_set       <= 1'b0;
      err_bad_cell  <= 1'b0;
      init_wea      <= '0;
      init_addr     <= '0;
      init_pdata    <= '0;
      init_vdata    <= '0;
      data_in_ready <= 1'b1;
      phase1_ready  <= 1'b0;
      phase3_ready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (tick) begin
      state_r       <= state_nx_s;
      load_cnt_r    <= load_cnt_nx_s;
      settle_cnt_r  <= settle_cnt_nx_s;
      n_steps_r     <= n_steps_nx_s;
      step_count    <= step_count_nx_s;
      double_buffer <= dbuf_nx_s;
      mem_set       <= mem_set_nx_s;
      err_bad_cell  <= err_nx_s;
      init_wea      <= wea_nx_s;
      init_addr     <= addr_nx_s;
      init_pdata    <= pdata_nx_s;
      init_vdata    <= vdata_nx_s;
      data_in_ready <= (state_nx_s == S_LOAD);
      // phase1_ready is held through SETTLE and drops as phase3_ready rises.
      phase1_ready  <= (state_nx_s == S_PHASE1) || (state_nx_s == S_SETTLE);
      phase3_ready  <= (state_nx_s == S_PHASE3);
      busy          <= (state_nx_s == S_PHASE1) || (state_nx_s == S_SETTLE) ||
                       (state_nx_s == S_PHASE3) || (state_nx_s == S_SWAP);
      done          <= (state_nx_s == S_DONE);
    end
  end

endmodule

// File: tb/tb_md_step_sequencer.sv
module tb_md_step_sequencer;
  localparam int N_CELL = 4;
  localparam int N_PARTICLES = 3;
  localparam int ADDR_W = 9;
  localparam int DIV = 2;
  localparam int SETTLE = 3;
  localparam int STEP_W = 16;

  // Reference-model phases (named after what the engine is doing).
  localparam int M_IDLE = 0, M_FORCE = 1, M_SETTLE = 2, M_MOTION = 3, M_SWAP = 4, M_FIN = 5;

  logic fast_clk = 1'b0;
  logic reset = 1'b1;
  logic data_in_valid = 1'b0;
  logic [255:0] data_in = '0;
  logic start = 1'b0;
  logic [STEP_W-1:0] n_steps = '0;
  logic p1_done = 1'b0;
  logic [N_CELL-1:0] p3_done = '0;
  logic data_in_ready, slow_clk, tick, mem_set, phase1_ready, phase3_ready, double_buffer;
  logic [N_CELL-1:0] init_wea;
  logic [ADDR_W-1:0] init_addr;
  logic [96:0] init_pdata, init_vdata;
  logic [STEP_W-1:0] step_count;
  logic busy, done, err_bad_cell;

  md_step_sequencer #(.N_CELL(N_CELL), .N_PARTICLES(N_PARTICLES), .ADDR_W(ADDR_W),
                      .DIV(DIV), .SETTLE(SETTLE), .STEP_W(STEP_W)) dut (
    .fast_clk(fast_clk), .reset(reset), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_in(data_in), .start(start), .n_steps(n_steps),
    .p1_done(p1_done), .p3_done(p3_done), .slow_clk(slow_clk), .tick(tick),
    .mem_set(mem_set), .phase1_ready(phase1_ready), .phase3_ready(phase3_ready),
    .double_buffer(double_buffer), .init_wea(init_wea), .init_addr(init_addr),
    .init_pdata(init_pdata), .init_vdata(init_vdata), .step_count(step_count),
    .busy(busy), .done(done), .err_bad_cell(err_bad_cell));

  always #5 fast_clk = ~fast_clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic v; logic [7:0] c; logic [8:0] a; logic s; logic [15:0] ns; logic p1; logic [3:0] p3;
    logic [3:0] wea; logic ms; logic rdy; logic err; logic p1r; logic p3r; logic db;
    logic [15:0] stp; logic dn; logic bsy;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] c, input logic [8:0] a,
      input logic s, input logic [15:0] ns, input logic p1, input logic [3:0] p3,
      input logic [3:0] wea, input logic ms, input logic rdy, input logic err,
      input logic p1r, input logic p3r, input logic db, input logic [15:0] stp,
      input logic dn, input logic bsy);
    vec_t r;
    r.v = v; r.c = c; r.a = a; r.s = s; r.ns = ns; r.p1 = p1; r.p3 = p3;
    r.wea = wea; r.ms = ms; r.rdy = rdy; r.err = err; r.p1r = p1r; r.p3r = p3r;
    r.db = db; r.stp = stp; r.dn = dn; r.bsy = bsy;
    return r;
  endfunction

  function automatic logic [255:0] mk_word(input logic [7:0] c, input logic [8:0] a);
    logic [255:0] w;
    w = '0;
    w[95:0] = {23'h0, a, 32'h5A5A0000, 24'h0, c};
    w[191:96] = ~w[95:0];
    w[199:192] = c;
    w[200 +: 9] = a;
    w[255:209] = 47'h1234;
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_wea, input logic e_ms,
      input logic e_rdy, input logic e_err, input logic e_p1r, input logic e_p3r,
      input logic e_db, input logic [15:0] e_stp, input logic e_dn, input logic e_bsy);
    chk({tag, ".init_wea"}, 128'(init_wea), 128'(e_wea));
    chk({tag, ".mem_set"}, 128'(mem_set), 128'(e_ms));
    chk({tag, ".data_in_ready"}, 128'(data_in_ready), 128'(e_rdy));
    chk({tag, ".err_bad_cell"}, 128'(err_bad_cell), 128'(e_err));
    chk({tag, ".phase1_ready"}, 128'(phase1_ready), 128'(e_p1r));
    chk({tag, ".phase3_ready"}, 128'(phase3_ready), 128'(e_p3r));
    chk({tag, ".double_buffer"}, 128'(double_buffer), 128'(e_db));
    chk({tag, ".step_count"}, 128'(step_count), 128'(e_stp));
    chk({tag, ".done"}, 128'(done), 128'(e_dn));
    chk({tag, ".busy"}, 128'(busy), 128'(e_bsy));
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [8:0] a, input logic s,
      input logic [15:0] ns, input logic p1, input logic [3:0] p3);
    data_in_valid = v;
    data_in = mk_word(c, a);
    start = s;
    n_steps = ns;
    p1_done = p1;
    p3_done = p3;
  endtask

  // Advance to just after the next update edge (the fast edge that samples tick=1).
  task automatic step();
    int n;
    @(negedge fast_clk);
    n = 1;
    while (tick !== 1'b1 && n < 4 * DIV) begin
      @(negedge fast_clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick within %0d cycles, expected one", 4 * DIV);
    end
    @(posedge fast_clk);
    #1;
  endtask

  logic [255:0] w;
  int m_ph, m_left, m_cnt;
  logic [15:0] m_n, m_stp;
  logic m_db, m_ms, m_err, st, p1v;
  logic [7:0] cv;
  logic [3:0] m_wea, p3v;
  logic [15:0] nsv;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge fast_clk);
    @(negedge fast_clk);
    check_outs("reset", 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("reset.slow_clk", 128'(slow_clk), 128'(0));
    chk("reset.tick", 128'(tick), 128'(0));
    chk("reset.init_addr", 128'(init_addr), 128'(0));

    // ---- divider: after n fast edges slow_clk = (n/DIV)%2, tick when n%(2*DIV)==DIV ----
    reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge fast_clk);
      chk($sformatf("div%0d.slow_clk", n), 128'(slow_clk), 128'((n / DIV) % 2));
      chk($sformatf("div%0d.tick", n), 128'(tick), 128'(n % (2 * DIV) == DIV));
    end

    // ---- table: load, run two steps, restart with 0 and 1 steps ----
    //                 v     cell   addr  st    nst    p1    p3     wea      ms    rdy   err   p1r   p3r   db    stp    dn    bsy
    tbl.push_back(mk(1'b1, 8'd2, 9'd5, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'd0, 9'd1, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'd3, 9'd7, 1'b1, 16'd5, 1'b0, 4'h0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'd1, 9'd2, 1'b0, 16'd0, 1'b1, 4'hF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b1, 16'd2, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b1, 16'd7, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b1, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b1, 4'h7, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b1, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b1, 4'hF, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b1, 16'd0, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'd0, 9'd0, 1'b1, 16'd1, 1'b0, 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1));
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].s, tbl[i].ns, tbl[i].p1, tbl[i].p3);
      step();
      check_outs($sformatf("row%0d", i), tbl[i].wea, tbl[i].ms, tbl[i].rdy, tbl[i].err,
                 tbl[i].p1r, tbl[i].p3r, tbl[i].db, tbl[i].stp, tbl[i].dn, tbl[i].bsy);
      if (tbl[i].wea != 4'b0) begin
        w = mk_word(tbl[i].c, tbl[i].a);
        chk($sformatf("row%0d.init_addr", i), 128'(init_addr), 128'(tbl[i].a));
        chk($sformatf("row%0d.init_pdata", i), 128'(init_pdata), 128'({1'b0, w[95:0]}));
        chk($sformatf("row%0d.init_vdata", i), 128'(init_vdata), 128'({1'b0, w[191:96]}));
      end
    end

    // ---- one-step run from PHASE1: settle is exactly SETTLE ticks ----
    drive(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b1, 4'h0);
    step();
    drive(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0);
    step();
    step();
    check_outs("settle2", 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    step();
    check_outs("settle3", 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'hF);
    step();
    step();
    check_outs("one_step_done", 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b0);

    // ---- restart with buffer 1, reach PHASE3, then reset mid-run ----
    drive(1'b0, 8'd0, 9'd0, 1'b1, 16'd1, 1'b0, 4'h0);
    step();
    check_outs("restart", 4'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b1, 4'h0);
    step();
    drive(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0);
    repeat (3) step();
    check_outs("pre_reset", 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1);
    p3_done = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("async_reset.slow_clk", 128'(slow_clk), 128'(0));
    repeat (3) @(posedge fast_clk);
    @(negedge fast_clk);
    reset = 1'b0;
    p3_done = 4'h0;
    step();
    check_outs("after_reset", 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // ---- bad cell among three loads ----
    drive(1'b1, 8'd1, 9'd3, 1'b0, 16'd0, 1'b0, 4'h0);
    step();
    check_outs("bad.w0", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 8'd9, 9'd4, 1'b0, 16'd0, 1'b0, 4'h0);
    step();
    check_outs("bad.w1", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    drive(1'b1, 8'd2, 9'd6, 1'b0, 16'd0, 1'b0, 4'h0);
    step();
    check_outs("bad.w2", 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 9'd0, 1'b0, 16'd0, 1'b0, 4'h0);
    step();
    check_outs("bad.idle", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

    // ---- randomized load and runs against the reference model ----
    reset = 1'b1;
    repeat (2) @(posedge fast_clk);
    @(negedge fast_clk);
    reset = 1'b0;
    m_cnt = 0; m_ms = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cv = 8'($urandom_range(0, 5));
      drive((k >= 12) ? 1'b1 : 1'($urandom), cv, 9'($urandom), 1'b0, 16'd0, 1'b0, 4'h0);
      step();
      m_wea = 4'b0;
      if (data_in_valid && !m_ms) begin
        if (cv < 4) m_wea = 4'(1) << cv;
        if (cv >= 4) m_err = 1'b1;
        m_cnt++;
        if (m_cnt == N_PARTICLES) m_ms = 1'b1;
      end
      check_outs($sformatf("rload%0d", k), m_wea, m_ms, !m_ms, m_err, 1'b0, 1'b0, 1'b0,
                 16'd0, 1'b0, 1'b0);
    end
    m_ph = M_IDLE; m_db = 1'b0; m_stp = 16'd0; m_n = 16'd0; m_left = 0;
    for (int k = 0; k < 300; k++) begin
      st  = ($urandom_range(0, 3) == 0);
      nsv = 16'($urandom_range(0, 3));
      p1v = ($urandom_range(0, 2) == 0);
      p3v = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      drive(1'($urandom), 8'($urandom_range(0, 5)), 9'($urandom), st, nsv, p1v, p3v);
      step();
      case (m_ph)
        M_IDLE, M_FIN: if (st) begin
          m_n = nsv; m_stp = 16'd0;
          m_ph = (nsv == 16'd0) ? M_FIN : M_FORCE;
        end
        M_FORCE: if (p1v) begin m_ph = M_SETTLE; m_left = SETTLE; end
        M_SETTLE: begin m_left--; if (m_left == 0) m_ph = M_MOTION; end
        M_MOTION: if (p3v == 4'hF) begin m_ph = M_SWAP; m_db = !m_db; m_stp++; end
        M_SWAP: m_ph = (m_stp == m_n) ? M_FIN : M_FORCE;
        default: m_ph = M_IDLE;
      endcase
      check_outs($sformatf("rrun%0d", k), 4'b0, 1'b1, 1'b0, m_err,
                 (m_ph == M_FORCE || m_ph == M_SETTLE), (m_ph == M_MOTION), m_db, m_stp,
                 (m_ph == M_FIN), (m_ph >= M_FORCE && m_ph <= M_SWAP));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_step_sequencer.md
Name: md_step_sequencer

Overview:
- Top-level timestep sequencer for the MD engine.
- Derives the slow compute clock from fast_clk and loads particle position/velocity words into per-cell BRAM write ports.
- Runs phase 1 (force) and phase 3 (motion update) for a programmable number of timesteps, toggling the double buffer each step.
- Parametrised, handshaked successor to the fixed-count init/phase control: adds backpressure, bad-cell detection, step counting and restart.

Parameters:
- N_CELL, 27, number of cells / BRAM pairs.
- N_PARTICLES, 300, words accepted in LOAD before mem_set.
- ADDR_W, 9, per-cell BRAM address width.
- DIV, 8, fast_clk cycles per slow_clk half-period (>=1).
- SETTLE, 99, slow ticks waited after p1_done before phase 3.
- STEP_W, 16, width of step counters.

Ports:
- fast_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- data_in_valid  in  1  load word present.
- data_in_ready  out  1  sequencer accepts word this tick.
- data_in  in  256  [95:0] pos, [191:96] vel, [199:192] cell, [200+:ADDR_W] addr.
- start  in  1  begin run (sampled on tick).
- n_steps  in  STEP_W  timesteps per run, latched at start.
- p1_done  in  1  phase-1 complete.
- p3_done  in  N_CELL  per-cell phase-3 complete.
- slow_clk  out  1  divided clock.
- tick  out  1  one fast_clk pulse per slow_clk rising edge.
- mem_set  out  1  memory loaded.
- phase1_ready  out  1  phase 1 owns BRAMs.
- phase3_ready  out  1  phase 3 owns BRAMs.
- double_buffer  out  1  active buffer select.
- init_wea  out  N_CELL  one-hot load write enable.
- init_addr  out  ADDR_W  load address.
- init_pdata  out  97  {1'b0,pos}.
- init_vdata  out  97  {1'b0,vel}.
- step_count  out  STEP_W  completed steps this run.
- busy  out  1  in PHASE1/SETTLE/PHASE3/SWAP.
- done  out  1  run finished.
- err_bad_cell  out  1  sticky: cell index >= N_CELL seen.

Behaviour:
- Reset (async): divider=0, slow_clk=0, tick=0, state=LOAD. All outputs 0 except data_in_ready=1. Load count=0.
- Divider: cnt counts 0..DIV-1 on fast_clk. At DIV-1, cnt wraps to 0 and slow_clk toggles. tick=1 for exactly the fast_clk cycle where slow_clk goes 0->1.
- All FSM/output registers update only on fast_clk edges where tick=1. Outputs are registered and hold between ticks.
- LOAD:
  - data_in_ready=1; accept when data_in_valid on tick.
  - Accepted word: next tick period drives init_wea[cell]=1, init_addr/pdata/vdata from the word.
  - init_wea is 0 in any period with no accept.
  - cell>=N_CELL: no write, err_bad_cell<=1, word still counted.
  - When count reaches N_PARTICLES: mem_set<=1, data_in_ready<=0, go WAIT_START on the same tick.
- WAIT_START:
  - On start: latch n_steps, step_count<=0, done<=0.
  - n_steps==0 -> DONE.
  - Otherwise -> PHASE1.
- PHASE1: phase1_ready=1. On p1_done -> SETTLE, settle counter=0.
- SETTLE:
  - phase1_ready stays 1; counter increments per tick.
  - At SETTLE-1 -> PHASE3 (phase1_ready drops when phase3_ready rises, same tick).
- PHASE3: phase3_ready=1. When &p3_done==1 -> SWAP.
- SWAP (one tick):
  - phase3_ready=0, double_buffer toggles, step_count+1.
  - If new step_count==latched n_steps -> DONE, else PHASE1.
- DONE: done=1, busy=0. start -> WAIT_START actions (restart from current double_buffer, mem not reloaded).
- Invariants:
  - phase1_ready & phase3_ready == 0 always.
  - Both are 0 in LOAD/WAIT_START/SWAP/DONE.
- Edge cases:
  - start asserted outside WAIT_START/DONE is ignored.
  - data_in_valid outside LOAD is ignored.
  - p1_done outside PHASE1 and p3_done outside PHASE3 are ignored.
  - Reset mid-run aborts immediately to LOAD; memory must be reloaded.

Test Plan:
1. N_CELL=4, N_PARTICLES=3, DIV=2: release reset. Expect slow_clk period 4 fast_clk cycles; tick every 4th cycle, one cycle wide.
2. Send words cell=2/addr=5, cell=0/addr=1, cell=3/addr=7, valid continuous. Expect init_wea=0100, 0001, 1000 on consecutive ticks; mem_set=1 and data_in_ready=0 after the 3rd accept.
3. Send cell=9 word among 3 loads. Expect err_bad_cell=1, init_wea=0 for that period, mem_set still after the 3rd accept.
4. n_steps=2, SETTLE=3, start. Pulse p1_done; expect exactly 3 ticks before phase3_ready=1. Hold p3_done=0111: no SWAP. Set 1111: double_buffer 0->1, step_count=1. Repeat: step_count=2, done=1, double_buffer=0.
5. n_steps=0, start -> done=1 next tick; phase1_ready never asserts.
6. Assert reset during PHASE3 -> all outputs 0 immediately, data_in_ready=1, state LOAD; a p3_done pulse during reset has no effect.
